drive_arbiter: RTL and testbench

- Resolves multiple would-be drivers of one signal into a single registered output through round-robin arbitration, so each net has exactly one driver.
- Each source presents a request and a data word. One source wins per transfer.
- The winning word is presented on a valid/ready output port, and the winner receives a one-cycle grant.
- Serves as the legal single-driver counterpart for sites that would otherwise need multiple assign or always drivers on one net.

---
 rtl/drive_arbiter.sv | 109 ++++++++++
 tb/tb_drive_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// rtl/drive_arbiter.sv - round-robin single-driver arbiter with registered valid/ready output
// Optional conflict counter enabled by macro DRIVE_ARBITER_CONFLICT_CNT_EN.
module drive_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = 2,
   parameter int PTR_W   = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC*DATA_W-1:0] data,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      conflict
`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
   ,
   output logic [7:0]                conflict_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t             state, state_d;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_d, win_idx;
   logic               any_req, multi_req, capture;
   logic               valid_d, conflict_d;
   logic [DATA_W-1:0]  data_d;
   logic [NUM_SRC-1:0] grant_d;

   assign any_req   = |req;
   assign multi_req = $countones(req) > 1;
   assign capture   = any_req && ((state == IDLE) || out_ready);

   // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
   always_comb begin
      win_idx = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % NUM_SRC])
            win_idx = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = any_req ? HOLD : IDLE;
         HOLD:    state_d = (out_ready && !any_req) ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d    = out_valid;
      data_d     = out_data;
      grant_d    = '0;
      conflict_d = 1'b0;
      rr_ptr_d   = rr_ptr;
      if (capture) begin
         valid_d    = 1'b1;
         data_d     = data[int'(win_idx)*DATA_W +: DATA_W];
         grant_d    = NUM_SRC'(1) << win_idx;
         conflict_d = multi_req;
         rr_ptr_d   = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
      end else begin
         case (state)
            IDLE:    valid_d = 1'b0;
            HOLD: begin
               // A stalled word keeps its conflict flag; a drained one clears.
               valid_d    = !out_ready;
               conflict_d = out_ready ? 1'b0 : conflict;
            end
            default: valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         grant     <= '0;
         conflict  <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         out_valid <= valid_d;
         out_data  <= data_d;
         grant     <= grant_d;
         conflict  <= conflict_d;
         rr_ptr    <= rr_ptr_d;
      end
   end

`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         conflict_cnt <= 8'd0;
      else if (capture && multi_req && conflict_cnt != 8'hff)
         conflict_cnt <= conflict_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_drive_arbiter.sv
// tb/tb_drive_arbiter.sv - self-checking bench for drive_arbiter
module tb_drive_arbiter;
   localparam int N = 2;
   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] data;
   logic           out_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [N-1:0]   grant;
   logic           conflict;
`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
   logic [7:0]     conflict_cnt;
`endif

   int total = 0;
   int bad   = 0;

   drive_arbiter #(.NUM_SRC(N), .DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .grant(grant), .conflict(conflict)
`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   req;
      logic [N*W-1:0] data;
      logic           ready;
      logic           v;
      logic [W-1:0]   d;
      logic [N-1:0]   g;
      logic           c;
   } vec_t;
   vec_t tv[20];

   // reference model: out_valid high means a word is being held
   logic         m_valid;
   logic [W-1:0] m_data;
   logic [N-1:0] m_grant;
   logic         m_conf;
   int           m_ptr;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_grant = '0; m_conf = 0; m_ptr = 0;
   endtask

   task automatic model_step();
      int w;
      int ones;
      if (m_valid && !out_ready) begin
         m_grant = '0;
      end else if (req != 0) begin
         w = -1;
         ones = 0;
         for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N] && w < 0) w = (m_ptr + k) % N;
            if (req[k]) ones++;
         end
         m_data  = W'(data >> (w * W));
         m_valid = 1;
         m_grant = N'(1) << w;
         m_conf  = ones > 1;
         m_ptr   = (w + 1) % N;
      end else begin
         m_valid = 0; m_grant = '0; m_conf = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 0; req = '1; data = '0; out_ready = 0;
      step();
      step();
      rst_n = 1;
      req = '0;
   endtask

   initial begin
      tv[0]  = '{2'b11, 4'b1001, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};
      tv[1]  = '{2'b11, 4'b1001, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
      tv[2]  = '{2'b11, 4'b1001, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};
      tv[3]  = '{2'b11, 4'b1001, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
      tv[4]  = '{2'b00, 4'b1001, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0};
      tv[5]  = '{2'b10, 4'b1000, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0};
      tv[6]  = '{2'b00, 4'b1000, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0};
      tv[7]  = '{2'b01, 4'b0011, 1'b0, 1'b1, 2'b11, 2'b01, 1'b0};
      tv[8]  = '{2'b11, 4'b0110, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0};
      tv[9]  = '{2'b11, 4'b1110, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0};
      tv[10] = '{2'b11, 4'b0110, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1};
      tv[11] = '{2'b01, 4'b0001, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0};
      tv[12] = '{2'b00, 4'b0001, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
      tv[13] = '{2'b00, 4'b0001, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
      tv[14] = '{2'b11, 4'b1001, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1};
      tv[15] = '{2'b11, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
      tv[16] = '{2'b11, 4'b1111, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
      tv[17] = '{2'b11, 4'b0101, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
      tv[18] = '{2'b11, 4'b0011, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
      tv[19] = '{2'b11, 4'b1001, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};

      rst_n = 0; req = 2'b11; data = 4'b1001; out_ready = 1;
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_data", out_data, 0);
`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
      chk("rst_cnt", conflict_cnt, 0);
`endif
      rst_n = 1;

      for (int i = 0; i < 20; i++) begin
         req = tv[i].req; data = tv[i].data; out_ready = tv[i].ready;
         step();
         chk($sformatf("vec%0d_valid", i), out_valid, tv[i].v);
         chk($sformatf("vec%0d_data", i), out_data, tv[i].d);
         chk($sformatf("vec%0d_grant", i), grant, tv[i].g);
         chk($sformatf("vec%0d_conflict", i), conflict, tv[i].c);
      end

      // async reset between edges while a word is held
      #3 rst_n = 0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_grant", grant, 0);
      @(posedge clk);
      #1 rst_n = 1; req = 2'b11; data = 4'b1001; out_ready = 1;
      step();
      chk("post_rst_grant", grant, 2'b01);
      chk("post_rst_data", out_data, 2'b01);

      do_reset();
      model_reset();
      for (int i = 0; i < 400; i++) begin
         req = N'($urandom);
         data = (N*W)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         model_step();
         step();
         chk("rand_valid", out_valid, m_valid);
         chk("rand_grant", grant, m_grant);
         chk("rand_conflict", conflict, m_conf);
         if (m_valid) chk("rand_data", out_data, m_data);
      end

`ifdef DRIVE_ARBITER_CONFLICT_CNT_EN
      do_reset();
      req = 2'b11; out_ready = 1;
      repeat (100) step();
      chk("cnt_100", conflict_cnt, 100);
      repeat (200) step();
      chk("cnt_sat", conflict_cnt, 255);
      rst_n = 0;
      #1;
      chk("cnt_clear", conflict_cnt, 0);
      rst_n = 1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
